// File: rtl/hazard_scoreboard_unit.sv
// Load-use hazard detection with a multi-cycle load scoreboard, freeze/flush priority
// control and a saturating stall counter.
module hazard_scoreboard_unit #(
    parameter int NB_REG_ADDR = 5,
    parameter int MEM_LATENCY = 2,
    parameter int NB_CNT      = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_id_ex_mem_read,
    input  logic [NB_REG_ADDR-1:0] i_id_ex_rd,
    input  logic [NB_REG_ADDR-1:0] i_if_id_rs1,
    input  logic [NB_REG_ADDR-1:0] i_if_id_rs2,
    input  logic                   i_rs1_used,
    input  logic                   i_rs2_used,
    input  logic                   i_flush,
    input  logic                   i_freeze,
    input  logic                   i_cnt_clear,
    output logic                   o_pc_write,
    output logic                   o_if_id_write,
    output logic                   o_control_mux,
    output logic                   o_if_id_flush,
    output logic                   o_pipe_hold,
    output logic [1:0]             o_state,
    output logic [NB_CNT-1:0]      o_stall_count
);

    // With MEM_LATENCY == 1 one dummy entry exists but is never marked valid.
    localparam int SB_N = (MEM_LATENCY > 1) ? (MEM_LATENCY - 1) : 1;

    typedef enum logic [1:0] {
        CLS_RUN    = 2'b00,
        CLS_STALL  = 2'b01,
        CLS_FREEZE = 2'b10,
        CLS_FLUSH  = 2'b11
    } cls_e;

    logic [SB_N-1:0]                  sb_valid_q, sb_valid_d;
    logic [SB_N-1:0][NB_REG_ADDR-1:0] sb_rd_q, sb_rd_d;
    cls_e                             state_q, state_d;
    logic [NB_CNT-1:0]                stall_count_q, stall_count_d;
    logic                             rs1_match;
    logic                             rs2_match;
    logic                             hazard;
    logic                             load_pushes;
    cls_e                             cycle_class;

    localparam logic [NB_CNT-1:0] CNT_MAX = {NB_CNT{1'b1}};
    localparam logic [NB_CNT-1:0] CNT_ONE = NB_CNT'(1);

    // A source conflicts with the load in ID/EX or any load still in flight.
    function automatic logic src_match(
        input logic                             used,
        input logic [NB_REG_ADDR-1:0]           src,
        input logic                             s0_valid,
        input logic [NB_REG_ADDR-1:0]           s0_rd,
        input logic [SB_N-1:0]                  v,
        input logic [SB_N-1:0][NB_REG_ADDR-1:0] rd
    );
        logic hit;
        hit = s0_valid && (s0_rd == src);
        for (int k = 0; k < SB_N; k++) begin
            hit = hit | (v[k] && (rd[k] == src));
        end
        return used && (src != '0) && hit;
    endfunction

    // Hazard detection across slot 0 and the registered scoreboard.
    always_comb begin
        rs1_match = src_match(i_rs1_used, i_if_id_rs1, i_id_ex_mem_read, i_id_ex_rd,
                              sb_valid_q, sb_rd_q);
        rs2_match = src_match(i_rs2_used, i_if_id_rs2, i_id_ex_mem_read, i_id_ex_rd,
                              sb_valid_q, sb_rd_q);
        hazard    = rs1_match | rs2_match;
    end

    // Cycle classification; reset is handled separately at the outputs and flops.
    always_comb begin
        cycle_class = CLS_RUN;
        if (i_freeze) begin
            cycle_class = CLS_FREEZE;
        end else if (i_flush) begin
            cycle_class = CLS_FLUSH;
        end else if (hazard) begin
            cycle_class = CLS_STALL;
        end else begin
            cycle_class = CLS_RUN;
        end
    end

    // Pipeline control outputs, combinational within the cycle.
    always_comb begin
        o_pc_write    = 1'b1;
        o_if_id_write = 1'b1;
        o_control_mux = 1'b0;
        o_if_id_flush = 1'b0;
        o_pipe_hold   = 1'b0;
        if (i_rst) begin
            o_pc_write    = 1'b0;
            o_if_id_write = 1'b0;
            o_control_mux = 1'b1;
        end else begin
            case (cycle_class)
                CLS_FREEZE: begin
                    o_pc_write    = 1'b0;
                    o_if_id_write = 1'b0;
                    o_pipe_hold   = 1'b1;
                end
                CLS_FLUSH: begin
                    o_control_mux = 1'b1;
                    o_if_id_flush = 1'b1;
                end
                CLS_STALL: begin
                    o_pc_write    = 1'b0;
                    o_if_id_write = 1'b0;
                    o_control_mux = 1'b1;
                end
                default: begin
                    o_pc_write    = 1'b1;
                    o_if_id_write = 1'b1;
                end
            endcase
        end
    end

    // Scoreboard shift; a flush does not clear in-flight loads.
    always_comb begin
        load_pushes = (MEM_LATENCY > 1) && i_id_ex_mem_read && (i_id_ex_rd != '0);
        sb_valid_d  = sb_valid_q;
        sb_rd_d     = sb_rd_q;
        if (!i_freeze) begin
            for (int k = SB_N - 1; k > 0; k--) begin
                sb_valid_d[k] = sb_valid_q[k-1];
                sb_rd_d[k]    = sb_rd_q[k-1];
            end
            sb_valid_d[0] = load_pushes;
            sb_rd_d[0]    = i_id_ex_rd;
        end else begin
            sb_valid_d = sb_valid_q;
            sb_rd_d    = sb_rd_q;
        end
    end

    // Class register and saturating stall counter; clear beats increment.
    always_comb begin
        state_d       = cycle_class;
        stall_count_d = stall_count_q;
        if (i_cnt_clear) begin
            stall_count_d = '0;
        end else if ((cycle_class == CLS_STALL) && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + CNT_ONE;
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sb_valid_q    <= '0;
            sb_rd_q       <= '0;
            state_q       <= CLS_RUN;
            stall_count_q <= '0;
        end else begin
            sb_valid_q    <= sb_valid_d;
            sb_rd_q       <= sb_rd_d;
            state_q       <= state_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign o_state       = state_q;
    assign o_stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Randomized and directed bench for hazard_scoreboard_unit: two instances (latency 2 and 3)
// checked every cycle against a list-based load-history model.
module tb_hazard_scoreboard_unit;

    logic       clk = 1'b0;
    logic       rst, mem_read, rs1_used, rs2_used, flush, freeze, cnt_clear;
    logic [4:0] id_ex_rd, rs1, rs2;

    logic       a_pc, a_ifw, a_mux, a_iff, a_hold;
    logic [1:0] a_state;
    logic [1:0] a_cnt;
    logic       b_pc, b_ifw, b_mux, b_iff, b_hold;
    logic [1:0] b_state;
    logic [3:0] b_cnt;

    int errors = 0;
    int checks = 0;

    // Model: per instance, list of load destinations still in flight (index 1 = newest).
    int         lat[2]  = '{2, 3};
    int         cmax[2] = '{3, 15};
    logic       m_v[2][8];
    logic [4:0] m_rd[2][8];
    int         m_cnt[2];
    int         m_state[2];
    int         stall_seen[2];

    always #5 clk = ~clk;

    hazard_scoreboard_unit #(.NB_REG_ADDR(5), .MEM_LATENCY(2), .NB_CNT(2)) u_dut_l2 (
        .i_clk(clk), .i_rst(rst), .i_id_ex_mem_read(mem_read), .i_id_ex_rd(id_ex_rd),
        .i_if_id_rs1(rs1), .i_if_id_rs2(rs2), .i_rs1_used(rs1_used), .i_rs2_used(rs2_used),
        .i_flush(flush), .i_freeze(freeze), .i_cnt_clear(cnt_clear),
        .o_pc_write(a_pc), .o_if_id_write(a_ifw), .o_control_mux(a_mux),
        .o_if_id_flush(a_iff), .o_pipe_hold(a_hold), .o_state(a_state), .o_stall_count(a_cnt)
    );

    hazard_scoreboard_unit #(.NB_REG_ADDR(5), .MEM_LATENCY(3), .NB_CNT(4)) u_dut_l3 (
        .i_clk(clk), .i_rst(rst), .i_id_ex_mem_read(mem_read), .i_id_ex_rd(id_ex_rd),
        .i_if_id_rs1(rs1), .i_if_id_rs2(rs2), .i_rs1_used(rs1_used), .i_rs2_used(rs2_used),
        .i_flush(flush), .i_freeze(freeze), .i_cnt_clear(cnt_clear),
        .o_pc_write(b_pc), .o_if_id_write(b_ifw), .o_control_mux(b_mux),
        .o_if_id_flush(b_iff), .o_pipe_hold(b_hold), .o_state(b_state), .o_stall_count(b_cnt)
    );

    function automatic logic m_src(int i, logic used, logic [4:0] s);
        logic hit;
        hit = 1'b0;
        if (!used || s == 5'd0) return 1'b0;
        if (mem_read && id_ex_rd == s) hit = 1'b1;
        for (int k = 1; k < lat[i]; k++)
            if (m_v[i][k] && m_rd[i][k] == s) hit = 1'b1;
        return hit;
    endfunction

    // 0 RUN, 1 STALL, 2 FREEZE, 3 FLUSH, 4 RESET
    function automatic int m_class(int i);
        if (rst) return 4;
        if (freeze) return 2;
        if (flush) return 3;
        if (m_src(i, rs1_used, rs1) || m_src(i, rs2_used, rs2)) return 1;
        return 0;
    endfunction

    function automatic int m_ctrl(int i);
        case (m_class(i))
            4: return 5'b00100;
            2: return 5'b00001;
            3: return 5'b11110;
            1: return 5'b00100;
            default: return 5'b11000;
        endcase
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 8; k++) begin
                m_v[i][k]  = 1'b0;
                m_rd[i][k] = 5'd0;
            end
            m_cnt[i]   = 0;
            m_state[i] = 0;
        end
    endtask

    task automatic update_model();
        for (int i = 0; i < 2; i++) begin
            int c;
            c = m_class(i);
            if (c == 4) begin
                for (int k = 0; k < 8; k++) m_v[i][k] = 1'b0;
                m_cnt[i]   = 0;
                m_state[i] = 0;
            end else begin
                if (!freeze) begin
                    for (int k = lat[i] - 1; k > 1; k--) begin
                        m_v[i][k]  = m_v[i][k-1];
                        m_rd[i][k] = m_rd[i][k-1];
                    end
                    m_v[i][1]  = mem_read && (id_ex_rd != 5'd0);
                    m_rd[i][1] = id_ex_rd;
                end
                m_state[i] = c;
                if (cnt_clear) m_cnt[i] = 0;
                else if (c == 1 && m_cnt[i] < cmax[i]) m_cnt[i] = m_cnt[i] + 1;
            end
        end
    endtask

    // Compare all DUT outputs against the model, mid-cycle.
    task automatic sample();
        @(negedge clk);
        check("l2_ctrl", {a_pc, a_ifw, a_mux, a_iff, a_hold}, m_ctrl(0));
        check("l2_state", a_state, m_state[0]);
        check("l2_count", a_cnt, m_cnt[0]);
        check("l3_ctrl", {b_pc, b_ifw, b_mux, b_iff, b_hold}, m_ctrl(1));
        check("l3_state", b_state, m_state[1]);
        check("l3_count", b_cnt, m_cnt[1]);
        for (int i = 0; i < 2; i++)
            if (m_class(i) == 1) stall_seen[i]++;
    endtask

    task automatic advance();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic idle();
        rst = 1'b0; mem_read = 1'b0; id_ex_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        rs1_used = 1'b0; rs2_used = 1'b0; flush = 1'b0; freeze = 1'b0; cnt_clear = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        sample();
        check("reset_ctrl", {a_pc, a_ifw, a_mux, a_iff, a_hold}, 5'b00100);
        check("reset_count", a_cnt, 0);
        advance();
        rst = 1'b0;

        // Load x5 then dependent user: L stall cycles.
        stall_seen = '{0, 0};
        mem_read = 1'b1; id_ex_rd = 5'd5; rs1 = 5'd5; rs1_used = 1'b1;
        step();
        mem_read = 1'b0; id_ex_rd = 5'd0;
        repeat (3) step();
        check("dep_stalls_l2", stall_seen[0], 2);
        check("dep_stalls_l3", stall_seen[1], 3);
        check("dep_count_l2", a_cnt, 2);
        check("dep_count_l3", b_cnt, 3);

        // One independent instruction in between: L-1 stall cycles.
        stall_seen = '{0, 0};
        mem_read = 1'b1; id_ex_rd = 5'd5; rs1 = 5'd1;
        step();
        mem_read = 1'b0; id_ex_rd = 5'd2; rs1 = 5'd5;
        repeat (3) step();
        check("gap_stalls_l2", stall_seen[0], 1);
        check("gap_stalls_l3", stall_seen[1], 2);
        check("gap_count_sat_l2", a_cnt, 3);
        check("gap_count_l3", b_cnt, 5);

        // x0 loads and unused sources never stall.
        stall_seen = '{0, 0};
        mem_read = 1'b1; id_ex_rd = 5'd0; rs1 = 5'd0; rs1_used = 1'b1;
        step();
        mem_read = 1'b1; id_ex_rd = 5'd7; rs1 = 5'd0; rs2 = 5'd7; rs2_used = 1'b0;
        step();
        mem_read = 1'b0; id_ex_rd = 5'd0;
        repeat (2) step();
        check("no_stall_l2", stall_seen[0], 0);
        check("no_stall_l3", stall_seen[1], 0);

        // Clear coincident with a stall wins.
        mem_read = 1'b1; id_ex_rd = 5'd5; rs1 = 5'd5; rs1_used = 1'b1; cnt_clear = 1'b1;
        step();
        check("clear_wins_l2", a_cnt, 0);
        check("clear_wins_l3", b_cnt, 0);
        idle();
        cnt_clear = 1'b1;
        repeat (3) step();
        cnt_clear = 1'b0;

        // Hazard with flush: FLUSH row, counter untouched, state 11.
        mem_read = 1'b1; id_ex_rd = 5'd6; rs2 = 5'd6; rs2_used = 1'b1; flush = 1'b1;
        sample();
        check("flush_ctrl", {a_pc, a_ifw, a_mux, a_iff, a_hold}, 5'b11110);
        advance();
        check("flush_state", a_state, 3);
        check("flush_count", a_cnt, 0);
        idle();
        repeat (3) step();

        // Freeze during a pending hazard; remaining stalls resume afterwards.
        stall_seen = '{0, 0};
        mem_read = 1'b1; id_ex_rd = 5'd5; rs1 = 5'd5; rs1_used = 1'b1;
        step();
        mem_read = 1'b0; id_ex_rd = 5'd0; freeze = 1'b1;
        repeat (3) begin
            sample();
            check("freeze_hold", a_hold, 1);
            advance();
        end
        check("freeze_state", b_state, 2);
        freeze = 1'b0;
        repeat (4) step();
        check("freeze_stalls_l2", stall_seen[0], 2);
        check("freeze_stalls_l3", stall_seen[1], 3);

        // Randomized traffic, small register range to provoke matches.
        repeat (3000) begin
            rst       = ($urandom_range(0, 63) == 0);
            freeze    = ($urandom_range(0, 7) == 0);
            flush     = ($urandom_range(0, 7) == 0);
            cnt_clear = ($urandom_range(0, 15) == 0);
            mem_read  = $urandom_range(0, 1);
            id_ex_rd  = 5'($urandom_range(0, 3));
            rs1       = 5'($urandom_range(0, 3));
            rs2       = 5'($urandom_range(0, 3));
            rs1_used  = $urandom_range(0, 1);
            rs2_used  = $urandom_range(0, 1);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard_unit.md
HAZARD_SCOREBOARD_UNIT -- requirements
Module: hazard_scoreboard_unit

Interface
REQ-001 Parameter NB_REG_ADDR, default 5: register-ID width.
REQ-002 Parameter MEM_LATENCY, default 2, legal 1..8: cycles from a load leaving ID/EX until its data is forwardable; 1 reproduces single-slot load-use detection.
REQ-003 Parameter NB_CNT, default 16: stall-counter width.
REQ-004 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-005 i_rst  in  1  synchronous, active-high reset.
REQ-006 i_id_ex_mem_read  in  1  instruction in ID/EX is a load.
REQ-007 i_id_ex_rd  in  NB_REG_ADDR  destination of the ID/EX instruction.
REQ-008 i_if_id_rs1 / i_if_id_rs2  in  NB_REG_ADDR each  sources of the IF/ID instruction.
REQ-009 i_rs1_used / i_rs2_used  in  1 each  IF/ID instruction actually reads rs1 / rs2.
REQ-010 i_flush  in  1  taken branch/jump: discard IF/ID and ID/EX contents.
REQ-011 i_freeze  in  1  debug halt: hold the entire pipeline.
REQ-012 i_cnt_clear  in  1  clear stall counter.
REQ-013 o_pc_write, o_if_id_write  out  1 each  write enables for PC and IF/ID.
REQ-014 o_control_mux  out  1  insert NOP into ID/EX.
REQ-015 o_if_id_flush  out  1  zero IF/ID on next edge.
REQ-016 o_pipe_hold  out  1  hold ID/EX and all downstream stage registers.
REQ-017 o_state  out  2  registered class of previous cycle: 00 RUN, 01 STALL, 10 FREEZE, 11 FLUSH.
REQ-018 o_stall_count  out  NB_CNT  saturating count of load-use stall cycles.

Function
REQ-019 Scoreboard: MEM_LATENCY-1 registered entries sb[1..MEM_LATENCY-1], each {valid, rd}; slot 0 is i_id_ex_mem_read/i_id_ex_rd, combinational and unregistered.
REQ-020 When i_freeze is 0, scoreboard shifts each edge: sb[1] <= {i_id_ex_mem_read && i_id_ex_rd != 0, i_id_ex_rd}; sb[k] <= sb[k-1]; oldest entry drops out.
REQ-021 When i_freeze is 1, scoreboard holds.
REQ-022 i_flush does not clear the scoreboard; the shift of REQ-020 still occurs.
REQ-023 Match on source s: s_used && s != 0 && (slot0 valid and rd == s, or any valid sb[k].rd == s).
REQ-024 hazard = match(rs1) or match(rs2); register x0 never causes a hazard.
REQ-025 Cycle class, priority high to low: RESET (i_rst), FREEZE (i_freeze), FLUSH (i_flush), STALL (hazard), RUN.
REQ-026 Control outputs are combinational within the cycle, as {pc_write, if_id_write, control_mux, if_id_flush, pipe_hold}:
- RESET: 0,0,1,0,0
- FREEZE: 0,0,0,0,1
- FLUSH: 1,1,1,1,0
- STALL: 0,0,1,0,0
- RUN: 1,1,0,0,0
REQ-027 A hazard coincident with i_flush or i_freeze produces no STALL class; after freeze release, hazard is re-evaluated from held state.
REQ-028 Stall duration is intrinsic: a load followed directly by a dependent instruction stalls exactly MEM_LATENCY cycles; with one independent instruction between them, MEM_LATENCY-1 cycles (minimum 0).
REQ-029 o_state <= class of current cycle each edge, FREEZE included.
REQ-030 o_stall_count increments by 1 on each STALL-class edge and saturates at all ones; i_cnt_clear zeroes it and wins over a coincident increment.

Reset
REQ-031 On an edge with i_rst=1: all scoreboard valids 0, o_state=00, o_stall_count=0; while i_rst=1, outputs per REQ-026 RESET row.
REQ-032 Reset asserted mid-stall aborts the stall; the first cycle after release is RUN unless slot 0 alone produces a hazard.

Verification
REQ-033 L=2: load x5 in ID/EX; next IF/ID instruction uses rs1=x5 -> exactly 2 STALL cycles, o_control_mux=1 in both, then RUN; o_stall_count=2.
REQ-034 L=2: load x5, one independent instruction, then a user of x5 -> exactly 1 stall cycle.
REQ-035 Load x0 followed by a user of x0, and load x7 followed by an instruction with rs2=x7 but i_rs2_used=0 -> no stall in either case.
REQ-036 Hazard present, i_flush=1 in the same cycle -> FLUSH outputs 1,1,1,1,0; o_stall_count unchanged; o_state=11 next cycle.
REQ-037 Hazard pending, i_freeze=1 for 3 cycles -> o_pipe_hold=1, scoreboard held; after release, remaining stall cycles complete unchanged.
REQ-038 NB_CNT=2: drive 5 stall cycles -> count saturates at 3; i_cnt_clear together with a stall -> count 0.
